// File: rtl/operand_input_capture_if.sv
// Operand entry bus: raw switch/button inputs toward the capture block
// and the captured operand pair with its status back out.
// Ports: sw, btn_load, btn_clear (raw board inputs);
//        in_1, in_2, operands_valid, new_pair, entry_stage (captured result).
interface operand_input_capture_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw;
    logic             btn_load;
    logic             btn_clear;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic             operands_valid;
    logic             new_pair;
    logic [1:0]       entry_stage;

    modport master (
        output sw, btn_load, btn_clear,
        input  in_1, in_2, operands_valid, new_pair, entry_stage
    );

    modport slave (
        input  sw, btn_load, btn_clear,
        output in_1, in_2, operands_valid, new_pair, entry_stage
    );
endinterface

// File: rtl/operand_input_capture.sv
// Synchronizes/debounces board buttons and switches, captures two operands.
// Ports: clk, rst (sync, active-high); bus (slave side of the entry bus).
module operand_input_capture #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input logic                  clk,
    input logic                  rst,
    operand_input_capture_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        READY  = 2'b10
    } state_t;

    logic [WIDTH-1:0] sw_s1;
    logic [WIDTH-1:0] sw_s2;
    // bit 0 = LOAD, bit 1 = CLEAR
    logic [1:0]       b_s1;
    logic [1:0]       b_s2;
    logic [1:0]       deb;
    logic [1:0]       deb_q;
    logic [1:0]       evt;
    logic [CNT_W-1:0] cnt [2];

    state_t           state;
    logic [WIDTH-1:0] in_1_r;
    logic [WIDTH-1:0] in_2_r;
    logic             valid_r;
    logic             new_pair_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            b_s1  <= '0;
            b_s2  <= '0;
            deb   <= '0;
            deb_q <= '0;
            evt   <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_s1 <= bus.sw;
            sw_s2 <= sw_s1;
            b_s1  <= {bus.btn_clear, bus.btn_load};
            b_s2  <= b_s1;
            deb_q <= deb;
            // Registered rising-edge pulse; releases never fire.
            evt   <= deb & ~deb_q;
            for (int i = 0; i < 2; i++) begin
                if (b_s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    deb[i] <= b_s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_A;
            in_1_r     <= '0;
            in_2_r     <= '0;
            valid_r    <= 1'b0;
            new_pair_r <= 1'b0;
        end else begin
            new_pair_r <= 1'b0;
            // Clear has priority; a coincident load is dropped.
            if (evt[1]) begin
                state   <= WAIT_A;
                in_1_r  <= '0;
                in_2_r  <= '0;
                valid_r <= 1'b0;
            end else if (evt[0]) begin
                unique case (1'b1)
                    (state == WAIT_A): begin
                        in_1_r  <= sw_s2;
                        state   <= WAIT_B;
                        valid_r <= 1'b0;
                    end
                    (state == WAIT_B): begin
                        in_2_r     <= sw_s2;
                        state      <= READY;
                        valid_r    <= 1'b1;
                        new_pair_r <= 1'b1;
                    end
                    (state == READY): begin
                        in_1_r  <= sw_s2;
                        state   <= WAIT_B;
                        valid_r <= 1'b0;
                    end
                    default: begin
                        state   <= WAIT_A;
                        valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.in_1           = in_1_r;
    assign bus.in_2           = in_2_r;
    assign bus.operands_valid = valid_r;
    assign bus.new_pair       = new_pair_r;
    assign bus.entry_stage    = state;
endmodule

// File: tb/tb_operand_input_capture.sv
// Directed bench for operand_input_capture with a change scoreboard.
// Ports: none; drives the entry bus master side.
module tb_operand_input_capture;
    logic clk = 1'b0;
    logic rst;

    operand_input_capture_if #(.WIDTH(4)) bus ();

    operand_input_capture #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [11:0] val;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    logic [11:0] prev = '0;
    int          c;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] mk(
        input logic np, input logic v, input logic [1:0] st,
        input logic [3:0] i2, input logic [3:0] i1
    );
        return {np, v, st, i2, i1};
    endfunction

    function automatic logic [11:0] obs_now();
        return {bus.new_pair, bus.operands_valid, bus.entry_stage,
                bus.in_2, bus.in_1};
    endfunction

    task automatic check(input string tag, input logic [31:0] o,
                         input logic [31:0] e);
        total++;
        assert (o === e) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input int cy, input logic [11:0] v);
        exp_t e;
        e.cyc = cy;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every change of the observed output tuple must match the next
    // scoreboard entry, both in value and in the cycle it appears.
    always @(negedge clk) begin
        logic [11:0] o;
        exp_t        e;
        if (mon_en) begin
            o = obs_now();
            if (o !== prev) begin
                if (q.size() == 0) begin
                    check("unexpected_change", {20'd0, o}, {20'd0, prev});
                end else begin
                    e = q.pop_front();
                    check("sb_val", {20'd0, o}, {20'd0, e.val});
                    check("sb_cyc", cyc, e.cyc);
                end
            end
            prev = o;
        end
    end

    initial begin
        rst           = 1'b1;
        bus.sw        = '0;
        bus.btn_load  = 1'b0;
        bus.btn_clear = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);
        mon_en = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle", {20'd0, obs_now()}, 32'd0);
        end

        // First operand then second operand.
        step(1);
        bus.sw = 4'h5;
        bus.btn_load = 1'b1;
        c = cyc;
        push(c + 8, mk(0, 0, 2'b01, 4'h0, 4'h5));
        step(10);
        bus.btn_load = 1'b0;
        step(10);
        @(negedge clk);
        check("after_a", {20'd0, obs_now()},
              {20'd0, mk(0, 0, 2'b01, 4'h0, 4'h5)});
        step(1);
        bus.sw = 4'hA;
        bus.btn_load = 1'b1;
        c = cyc;
        push(c + 8, mk(1, 1, 2'b10, 4'hA, 4'h5));
        push(c + 9, mk(0, 1, 2'b10, 4'hA, 4'h5));
        step(10);
        bus.btn_load = 1'b0;
        step(10);
        @(negedge clk);
        check("pair", {20'd0, obs_now()},
              {20'd0, mk(0, 1, 2'b10, 4'hA, 4'h5)});

        // Short glitch is rejected, then a real press reloads in_1.
        step(1);
        bus.sw = 4'h3;
        bus.btn_load = 1'b1;
        step(3);
        bus.btn_load = 1'b0;
        step(10);
        @(negedge clk);
        check("glitch", {20'd0, obs_now()},
              {20'd0, mk(0, 1, 2'b10, 4'hA, 4'h5)});
        step(1);
        bus.btn_load = 1'b1;
        c = cyc;
        push(c + 8, mk(0, 0, 2'b01, 4'hA, 4'h3));
        step(10);
        bus.btn_load = 1'b0;
        step(10);
        @(negedge clk);
        check("reload", {20'd0, obs_now()},
              {20'd0, mk(0, 0, 2'b01, 4'hA, 4'h3)});

        // Back to READY, then load and clear together.
        step(1);
        bus.sw = 4'h7;
        bus.btn_load = 1'b1;
        c = cyc;
        push(c + 8, mk(1, 1, 2'b10, 4'h7, 4'h3));
        push(c + 9, mk(0, 1, 2'b10, 4'h7, 4'h3));
        step(10);
        bus.btn_load = 1'b0;
        step(10);
        bus.sw = 4'h6;
        bus.btn_load = 1'b1;
        bus.btn_clear = 1'b1;
        c = cyc;
        push(c + 8, mk(0, 0, 2'b00, 4'h0, 4'h0));
        step(10);
        bus.btn_load = 1'b0;
        bus.btn_clear = 1'b0;
        step(10);
        @(negedge clk);
        check("clear_wins", {20'd0, obs_now()}, 32'd0);

        // Long hold: one capture; sw changes mid-debounce.
        step(1);
        bus.sw = 4'h9;
        bus.btn_load = 1'b1;
        c = cyc;
        push(c + 8, mk(0, 0, 2'b01, 4'h0, 4'hB));
        step(2);
        bus.sw = 4'hB;
        step(48);
        bus.btn_load = 1'b0;
        step(10);
        @(negedge clk);
        check("long_hold", {20'd0, obs_now()},
              {20'd0, mk(0, 0, 2'b01, 4'h0, 4'hB)});

        // Reset inside the WAIT_B debounce window with LOAD held.
        step(1);
        bus.sw = 4'hC;
        bus.btn_load = 1'b1;
        step(2);
        rst = 1'b1;
        c = cyc;
        push(c + 1, mk(0, 0, 2'b00, 4'h0, 4'h0));
        step(1);
        rst = 1'b0;
        bus.sw = 4'hE;
        push(c + 9, mk(0, 0, 2'b01, 4'h0, 4'hE));
        step(15);
        bus.btn_load = 1'b0;
        step(10);
        @(negedge clk);
        check("post_rst", {20'd0, obs_now()},
              {20'd0, mk(0, 0, 2'b01, 4'h0, 4'hE)});

        check("sb_drained", q.size(), 0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/operand_input_capture.md
Name: operand_input_capture

Overview:
- Front-end input block for the two-operand/display datapath. It is the input end of the chain, where the display driver is the output end.
- Synchronizes and debounces the board push-buttons and the switch bank.
- The operator enters two operands in sequence on the shared switch bank. Each entry is confirmed with a LOAD button press.
- The block presents registered in_1/in_2 with a valid indication to downstream arithmetic/display logic.

Parameters:
- WIDTH, 4, operand width; also the switch-bank width.
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronized samples required before the debounced button level changes. Minimum 2. Benches use 4.
- CNT_W, 18, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; the single clock domain.
- rst  input  1  synchronous, active-high reset.
- sw  input  WIDTH  raw switch bank, asynchronous.
- btn_load  input  1  raw LOAD push-button, asynchronous, active-high.
- btn_clear  input  1  raw CLEAR push-button, asynchronous, active-high.
- in_1  output  WIDTH  captured first operand, registered.
- in_2  output  WIDTH  captured second operand, registered.
- operands_valid  output  1  high while in READY state.
- new_pair  output  1  one-cycle pulse on the cycle operands_valid rises.
- entry_stage  output  2  00=WAIT_A, 01=WAIT_B, 10=READY; 11 unused.

Behaviour:
- Clock and reset:
  - Single clock; clk is the only edge used.
  - rst is sampled on the rising edge of clk.
  - Reset values: in_1=0, in_2=0, operands_valid=0, new_pair=0, entry_stage=00.
  - All synchronizer flops, debounced levels, counters and edge registers clear to 0 on reset.
- Synchronization:
  - sw, btn_load and btn_clear each pass through a 2-flop synchronizer.
  - The capture logic only ever uses synchronized sw.
- Debounce, per button:
  - The counter clears whenever the synchronized level equals the debounced level.
  - Otherwise it increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the debounced level takes the synchronized level and the counter clears.
  - Any reversion to the debounced level before then clears the counter. Glitches shorter than DEBOUNCE_CYCLES are fully rejected.
- Event detection:
  - load_evt/clear_evt is a one-cycle pulse on a debounced rising edge.
  - Release edges generate no event.
  - Holding a button generates exactly one event.
- Latency: a raw button rising at clock edge k, then held, gives an event pulse in cycle k+DEBOUNCE_CYCLES+2. The resulting register update is visible at edge k+DEBOUNCE_CYCLES+3.
- State machine:
  - WAIT_A + load_evt: in_1 <= sw_sync; go to WAIT_B.
  - WAIT_B + load_evt: in_2 <= sw_sync; go to READY; new_pair=1 for that single cycle.
  - READY + load_evt: in_1 <= sw_sync; go to WAIT_B. in_2 is held; operands_valid drops.
  - Any state + clear_evt: go to WAIT_A; in_1=0, in_2=0.
  - No event: state and operands hold.
- Boundary conditions:
  - Simultaneous load_evt and clear_evt: clear wins and the load is discarded.
  - rst asserted mid-debounce or mid-entry: everything returns to reset values. A button still held when rst deasserts produces a press event once it is debounced, because the debounced level restarts at 0.
  - sw changing during debounce: the value captured is sw_sync in the event cycle, not the value at press time.
  - operands_valid and entry_stage are registered state decodes; they are not combinational on inputs.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=4):
- Reset, then hold all inputs 0 for 20 cycles -> all outputs 0 and entry_stage=00 throughout.
- sw=0x5, press LOAD for 10 cycles, release; then sw=0xA, press LOAD for 10 cycles -> in_1=0x5 at edge 7 after the first press. After the second press: in_2=0xA, entry_stage=10, operands_valid=1, and new_pair high exactly one cycle.
- With the pair loaded, pulse btn_load high for 3 cycles (glitch) -> no state or operand change. Then a 10-cycle press with sw=0x3 -> in_1=0x3, in_2 still 0xA, entry_stage=01, operands_valid=0.
- Raise LOAD and CLEAR on the same cycle and hold both for 10 cycles from READY -> entry_stage=00, in_1=0, in_2=0, and no capture.
- Hold LOAD for 50 cycles starting from WAIT_A -> exactly one capture into in_1 and entry_stage=01, with no advance to READY.
- Assert rst for 1 cycle during the WAIT_B debounce window -> outputs return to reset values. LOAD still held afterwards produces one capture into in_1 DEBOUNCE_CYCLES+3 cycles after rst deasserts.
